sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency SRAM between the CPU instruction fetch port (I) and the load/store port (D).
- Sits between mycpu_top's inst_sram_*/data_sram_* pins and the unified memory model or macro.
- D has fixed priority, with a starvation guard that promotes I.
- Routes registered read data back to the owning requester and supports cancelling an outstanding fetch (branch flush).

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte strobes are DATA_W/8 wide.
- STARVE_MAX, 4, consecutive denied I-request cycles before I is promoted; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr stable until i_gnt.
- i_addr  in  ADDR_W  fetch byte address.
- i_flush  in  1  cancels the fetch response due this cycle.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  i_rdata valid.
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  DATA_W/8  byte write strobes; 0 means read.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  d_rdata valid (reads only).
- d_rdata  out  DATA_W  load word.
- sram_en  out  1  SRAM access enable.
- sram_we  out  DATA_W/8  SRAM byte strobes.
- sram_addr  out  ADDR_W  SRAM address, passed through unmodified.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after a read enable.
- starve_evt  out  1  one-cycle pulse when I is promoted (performance counter hook).

Behaviour:
- Priority FSM, two states:
  - PRIO_D (reset state): d_req wins.
  - PRIO_I: i_req wins.
  - PRIO_D to PRIO_I when starve_cnt reaches STARVE_MAX; starve_evt pulses in the cycle the transition is registered.
  - PRIO_I to PRIO_D on the cycle I is granted, or when i_req is 0.
- starve_cnt (4 bits):
  - Increments when i_req and not i_gnt; saturates at STARVE_MAX.
  - Clears when i_gnt=1 or i_req=0.
- Grant, combinational from req and state:
  - At most one of i_gnt/d_gnt is 1.
  - A grant is never given without the matching req.
  - Lone requester is always granted the same cycle.
- SRAM drive, combinational mux of the granted requester:
  - sram_en = i_gnt | d_gnt.
  - sram_we = d_we when D is granted, else 0; I never writes.
  - With no grant: sram_we=0, sram_addr=0, sram_wdata=0.
- Response pipeline (registers rsp_v, rsp_own):
  - rsp_v <= grant AND read.
  - rsp_own <= granted port.
  - Next cycle: x_rvalid = rsp_v & (rsp_own==x); x_rdata = sram_rdata when x_rvalid, else 0.
  - Read latency is exactly 1 cycle from gnt.
  - A write grant produces no rvalid.
- Back-to-back: a new grant may issue in the same cycle an earlier response returns; full throughput is one access per cycle.
- i_flush:
  - Forces i_rvalid=0 and i_rdata=0 in the cycle it is asserted.
  - Does not affect a grant issued in that same cycle; that response returns normally next cycle.
  - No effect on d_rvalid.
- Reset:
  - All outputs 0, state PRIO_D, starve_cnt 0, rsp_v 0.
  - A read granted in the cycle before reset returns no rvalid.
  - Requests held during reset are granted no earlier than the first cycle after reset deasserts.
- No internal FIFO: requesters stall on !gnt; the arbiter never buffers a request.

Decomposition:
- Shared package holds:
  - arb_owner_e {OWN_I=0, OWN_D=1};
  - prio_state_e {PRIO_D, PRIO_I};
  - the STARVE_CNT_W=4 constant;
  - the SRAM request struct (en, we, addr, wdata) reused by the memory model.
- One sub-module, arb_starve_ctr: saturating counter plus the promote/demote FSM, output prio_i.
- Grant mux and response pipeline stay in the top.

Test Plan:
- Lone I: i_req=1, i_addr=0x10, sram word 0x00432020 -> i_gnt=1 at cycle t; i_rvalid=1 with i_rdata=0x00432020 at t+1; d_rvalid=0 throughout.
- Contention: both requests continuously, d_we=0 -> D granted cycles t..t+3; starve_evt at t+4; I granted t+5; D granted again t+6.
- Store: d_req with d_we=4'hF, d_addr=0x0, d_wdata=0x0000000A, then D read of 0x0 -> write has no rvalid; read returns 0x0000000A one cycle after its gnt.
- Flush: I granted at t, i_flush=1 at t+1 -> i_rvalid=0 at t+1. New I grant at t+1 (addr 0x2C) -> i_rvalid=1 at t+2.
- Reset mid-op: D read granted at t, reset=1 at t+1 -> d_rvalid=0 at t+1 and t+2; state PRIO_D; no grant while reset=1.
- Interleave: alternating I/D single requests for 20 cycles -> each rvalid lands 1 cycle after its gnt at the correct port; never two grants in one cycle.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the I/D single-port SRAM arbiter and its memory model.
package sram_port_arbiter_pkg;

  localparam int unsigned STARVE_CNT_W = 4;
  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 32;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  typedef enum logic {
    PRIO_D = 1'b0,
    PRIO_I = 1'b1
  } prio_state_e;

  typedef struct packed {
    logic                      en;
    logic [DATA_W_DEF/8-1:0]   we;
    logic [ADDR_W_DEF-1:0]     addr;
    logic [DATA_W_DEF-1:0]     wdata;
  } sram_req_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Starvation guard: counts denied fetch cycles and promotes the fetch port once the limit is hit.
module arb_starve_ctr
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_gnt,
  output logic prio_i,
  output logic starve_evt
);

  localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(STARVE_MAX);

  prio_state_e               state_q, state_d;
  logic [STARVE_CNT_W-1:0]   cnt_q, cnt_d;
  logic                      evt_q, evt_d;

  // evt_d is the promote condition one cycle early, so the registered pulse lines up with the transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    if (i_req && !i_gnt) begin
      cnt_d = (cnt_q >= MAX_C) ? MAX_C : cnt_q + STARVE_CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
    case (state_q)
      PRIO_D:  if (cnt_q >= MAX_C) state_d = PRIO_I;
      PRIO_I:  if (i_gnt || !i_req) state_d = PRIO_D;
      default: state_d = PRIO_D;
    endcase
    evt_d = (state_d == PRIO_D) && (cnt_d >= MAX_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PRIO_D;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign prio_i     = (state_q == PRIO_I);
  assign starve_evt = evt_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1-cycle-latency single-port SRAM between the fetch (I) and load/store (D) ports.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_flush,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic [DATA_W/8-1:0]   d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  sram_en,
  output logic [DATA_W/8-1:0]   sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic                  starve_evt
);

  logic        prio_i;
  logic        evt;
  logic        i_gnt_c, d_gnt_c;
  logic        rsp_v_q, rsp_v_d;
  arb_owner_e  rsp_own_q, rsp_own_d;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_gnt      (i_gnt_c),
    .prio_i     (prio_i),
    .starve_evt (evt)
  );

  // Grants are held off during reset so requests waiting through reset start cleanly afterwards
  always_comb begin
    i_gnt_c = 1'b0;
    d_gnt_c = 1'b0;
    if (!reset) begin
      if (i_req && d_req) begin
        i_gnt_c = prio_i;
        d_gnt_c = !prio_i;
      end else begin
        i_gnt_c = i_req;
        d_gnt_c = d_req;
      end
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (d_gnt_c) begin
      sram_en    = 1'b1;
      sram_we    = d_we;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end else if (i_gnt_c) begin
      sram_en    = 1'b1;
      sram_addr  = i_addr;
    end
  end

  always_comb begin
    rsp_v_d   = i_gnt_c || (d_gnt_c && (d_we == '0));
    rsp_own_d = d_gnt_c ? OWN_D : OWN_I;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_v_q   <= 1'b0;
      rsp_own_q <= OWN_I;
    end else begin
      rsp_v_q   <= rsp_v_d;
      rsp_own_q <= rsp_own_d;
    end
  end

  // A response in flight when reset hits is dropped, and a flush only suppresses the fetch side
  assign i_gnt      = i_gnt_c;
  assign d_gnt      = d_gnt_c;
  assign i_rvalid   = rsp_v_q && (rsp_own_q == OWN_I) && !i_flush && !reset;
  assign d_rvalid   = rsp_v_q && (rsp_own_q == OWN_D) && !reset;
  assign i_rdata    = i_rvalid ? sram_rdata : '0;
  assign d_rdata    = d_rvalid ? sram_rdata : '0;
  assign starve_evt = evt && !reset;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: vector table, hand-written corner sequences and a random run against a reference model.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  localparam int SMAX = 4;

  logic        clk, reset;
  logic        i_req, i_flush, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_gnt, d_rvalid;
  logic [3:0]  d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        sram_en, starve_evt;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .starve_evt(starve_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h0043_2020;
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // 16-word memory model; reloads its image whenever reset is high
  logic [31:0] mem [16];
  sram_req_t   req_s;
  assign req_s = {sram_en, sram_we, sram_addr, sram_wdata};

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (req_s.en) begin
      if (req_s.we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (req_s.we[b]) mem[req_s.addr[5:2]][8*b +: 8] <= req_s.wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[req_s.addr[5:2]];
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        fl;
    logic        dr;
    logic [3:0]  dwe;
    logic [31:0] da;
    logic [31:0] dwd;
  } in_t;

  typedef struct {
    in_t         in;
    logic        e_ig;
    logic        e_dg;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_drv;
    logic [31:0] e_drd;
    logic        e_evt;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        m_prio_i;
  int          m_starve;
  logic        m_rsp_v, m_rsp_d;
  logic [31:0] m_rsp_data;
  logic [31:0] shadow [16];
  logic        m_ig, m_dg;

  // DUT outputs as seen at the check point of the last cycle
  logic        obs_ig, obs_dg, obs_irv, obs_drv, obs_evt;
  logic [31:0] obs_ird, obs_drd;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic rst, input logic ir, input logic [31:0] ia, input logic fl,
                             input logic dr, input logic [3:0] dwe, input logic [31:0] da,
                             input logic [31:0] dwd);
    in_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.fl = fl;
    v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
    return v;
  endfunction

  // One clock: drive at negedge, check 2ns later, advance the model, wait for the next negedge
  task automatic run_cycle(input in_t v);
    logic        e_ig, e_dg, e_irv, e_drv, e_evt, e_en, np;
    logic [3:0]  e_we;
    logic [31:0] e_ird, e_drd, e_addr, e_wd;
    int          idx;
    reset = v.rst; i_req = v.ir; i_addr = v.ia; i_flush = v.fl;
    d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
    #2;
    e_evt = !v.rst && !m_prio_i && (m_starve >= SMAX);
    if (v.rst) begin
      e_ig = 1'b0; e_dg = 1'b0;
    end else if (v.ir && v.dr) begin
      e_ig = m_prio_i; e_dg = !m_prio_i;
    end else begin
      e_ig = v.ir; e_dg = v.dr;
    end
    e_irv  = !v.rst && m_rsp_v && !m_rsp_d && !v.fl;
    e_drv  = !v.rst && m_rsp_v && m_rsp_d;
    e_ird  = e_irv ? m_rsp_data : 32'h0;
    e_drd  = e_drv ? m_rsp_data : 32'h0;
    e_en   = e_ig || e_dg;
    e_we   = e_dg ? v.dwe : 4'h0;
    e_addr = e_dg ? v.da : (e_ig ? v.ia : 32'h0);
    e_wd   = e_dg ? v.dwd : 32'h0;
    chk_b("i_gnt", i_gnt, e_ig);
    chk_b("d_gnt", d_gnt, e_dg);
    chk_b("i_rvalid", i_rvalid, e_irv);
    chk_w("i_rdata", i_rdata, e_ird);
    chk_b("d_rvalid", d_rvalid, e_drv);
    chk_w("d_rdata", d_rdata, e_drd);
    chk_b("sram_en", sram_en, e_en);
    chk_w("sram_we", 32'(sram_we), 32'(e_we));
    chk_w("sram_addr", sram_addr, e_addr);
    chk_w("sram_wdata", sram_wdata, e_wd);
    chk_b("starve_evt", starve_evt, e_evt);
    obs_ig = i_gnt; obs_dg = d_gnt; obs_irv = i_rvalid; obs_drv = d_rvalid;
    obs_ird = i_rdata; obs_drd = d_rdata; obs_evt = starve_evt;
    m_ig = e_ig; m_dg = e_dg;
    if (v.rst) begin
      m_prio_i = 1'b0; m_starve = 0; m_rsp_v = 1'b0; m_rsp_d = 1'b0;
      for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
    end else begin
      idx = int'(e_addr[5:2]);
      m_rsp_v = e_ig || (e_dg && v.dwe == 4'h0);
      m_rsp_d = e_dg;
      m_rsp_data = shadow[idx];
      if (e_dg)
        for (int b = 0; b < 4; b++)
          if (v.dwe[b]) shadow[idx][8*b +: 8] = v.dwd[8*b +: 8];
      np = m_prio_i;
      if (!m_prio_i && m_starve >= SMAX) np = 1'b1;
      else if (m_prio_i && (e_ig || !v.ir)) np = 1'b0;
      m_prio_i = np;
      if (v.ir && !e_ig) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
      else m_starve = 0;
    end
    @(negedge clk);
  endtask

  vec_t tbl [9];
  in_t  idle, rst_v, v;
  logic pi, pd;

  initial begin
    m_prio_i = 1'b0; m_starve = 0; m_rsp_v = 1'b0; m_rsp_d = 1'b0; m_rsp_data = 32'h0;
    for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
    reset = 1'b1; i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    idle  = mk(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    rst_v = mk(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    //               rst ir  ia        fl dr dwe   da         dwd            ig dg irv ird           drv drd           evt
    tbl[0] = '{'{0, 1, 32'h10, 0, 0, 4'h0, 32'h00, 32'h0},         1, 0, 0, 32'h0,         0, 32'h0,         0};
    tbl[1] = '{'{0, 0, 32'h00, 0, 0, 4'h0, 32'h00, 32'h0},         0, 0, 1, 32'h0043_2020, 0, 32'h0,         0};
    tbl[2] = '{'{0, 0, 32'h00, 0, 1, 4'h0, 32'h14, 32'h0},         0, 1, 0, 32'h0,         0, 32'h0,         0};
    tbl[3] = '{'{0, 1, 32'h18, 0, 1, 4'h0, 32'h1C, 32'h0},         0, 1, 0, 32'h0,         1, 32'hC0DE_0005, 0};
    tbl[4] = '{'{0, 1, 32'h18, 0, 1, 4'hF, 32'h20, 32'h1234_5678}, 0, 1, 0, 32'h0,         1, 32'hC0DE_0007, 0};
    tbl[5] = '{'{0, 1, 32'h18, 0, 0, 4'h0, 32'h00, 32'h0},         1, 0, 0, 32'h0,         0, 32'h0,         0};
    tbl[6] = '{'{0, 0, 32'h00, 0, 0, 4'h0, 32'h00, 32'h0},         0, 0, 1, 32'hC0DE_0006, 0, 32'h0,         0};
    tbl[7] = '{'{0, 0, 32'h00, 0, 1, 4'h0, 32'h20, 32'h0},         0, 1, 0, 32'h0,         0, 32'h0,         0};
    tbl[8] = '{'{0, 0, 32'h00, 0, 0, 4'h0, 32'h00, 32'h0},         0, 0, 0, 32'h0,         1, 32'h1234_5678, 0};

    @(negedge clk);
    run_cycle(rst_v);
    run_cycle(rst_v);

    for (int k = 0; k < 9; k++) begin
      run_cycle(tbl[k].in);
      chk_b($sformatf("tbl%0d_ig", k), obs_ig, tbl[k].e_ig);
      chk_b($sformatf("tbl%0d_dg", k), obs_dg, tbl[k].e_dg);
      chk_b($sformatf("tbl%0d_irv", k), obs_irv, tbl[k].e_irv);
      chk_w($sformatf("tbl%0d_ird", k), obs_ird, tbl[k].e_ird);
      chk_b($sformatf("tbl%0d_drv", k), obs_drv, tbl[k].e_drv);
      chk_w($sformatf("tbl%0d_drd", k), obs_drd, tbl[k].e_drd);
      chk_b($sformatf("tbl%0d_evt", k), obs_evt, tbl[k].e_evt);
    end

    // Contention: D wins until the guard fires, then I gets exactly one slot
    run_cycle(rst_v);
    for (int k = 0; k < 7; k++) begin
      run_cycle(mk(0, k <= 5, 32'h30, 0, 1, 4'h0, 32'h34, 32'h0));
      if (k != 4) chk_b($sformatf("cont%0d_dg", k), obs_dg, k != 5);
      chk_b($sformatf("cont%0d_ig", k), obs_ig, k == 5);
      chk_b($sformatf("cont%0d_evt", k), obs_evt, k == 4);
    end

    // Store then load of the same word
    run_cycle(rst_v);
    run_cycle(mk(0, 0, 32'h0, 0, 1, 4'hF, 32'h0, 32'h0000_000A));
    chk_b("store_gnt", obs_dg, 1'b1);
    run_cycle(mk(0, 0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0));
    chk_b("store_no_rvalid", obs_drv, 1'b0);
    run_cycle(idle);
    chk_b("load_rvalid", obs_drv, 1'b1);
    chk_w("load_rdata", obs_drd, 32'h0000_000A);

    // Flush kills the returning fetch but not the fetch granted alongside it
    run_cycle(mk(0, 1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0));
    run_cycle(mk(0, 1, 32'h2C, 1, 0, 4'h0, 32'h0, 32'h0));
    chk_b("flush_irv", obs_irv, 1'b0);
    chk_w("flush_ird", obs_ird, 32'h0);
    chk_b("flush_new_gnt", obs_ig, 1'b1);
    run_cycle(idle);
    chk_b("after_flush_irv", obs_irv, 1'b1);
    chk_w("after_flush_ird", obs_ird, 32'hC0DE_000B);

    // Reset while a load is in flight
    run_cycle(mk(0, 0, 32'h0, 0, 1, 4'h0, 32'h14, 32'h0));
    run_cycle(mk(1, 1, 32'h30, 0, 1, 4'h0, 32'h14, 32'h0));
    chk_b("rst_drv", obs_drv, 1'b0);
    chk_b("rst_no_dg", obs_dg, 1'b0);
    chk_b("rst_no_ig", obs_ig, 1'b0);
    run_cycle(mk(0, 1, 32'h30, 0, 1, 4'h0, 32'h14, 32'h0));
    chk_b("post_rst_drv", obs_drv, 1'b0);
    chk_b("post_rst_dg", obs_dg, 1'b1);
    chk_b("post_rst_ig", obs_ig, 1'b0);
    run_cycle(mk(0, 1, 32'h30, 0, 0, 4'h0, 32'h0, 32'h0));
    run_cycle(idle);

    // Alternating single requests
    run_cycle(rst_v);
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) run_cycle(mk(0, 1, 32'((k % 16) * 4), 0, 0, 4'h0, 32'h0, 32'h0));
      else            run_cycle(mk(0, 0, 32'h0, 0, 1, 4'h0, 32'(((k + 3) % 16) * 4), 32'h0));
      chk_b($sformatf("il%0d_one_gnt", k), obs_ig & obs_dg, 1'b0);
      if (k > 0) begin
        chk_b($sformatf("il%0d_irv", k), obs_irv, (k % 2) == 1);
        chk_b($sformatf("il%0d_drv", k), obs_drv, (k % 2) == 0);
      end
    end

    // Random traffic obeying the hold-until-granted protocol
    pi = 1'b0; pd = 1'b0; v = idle;
    for (int c = 0; c < 3000; c++) begin
      if (!pi) begin
        pi = ($urandom % 3) != 0;
        v.ia = 32'($urandom_range(0, 15) * 4);
      end
      if (!pd) begin
        pd = ($urandom % 3) != 0;
        v.da = 32'($urandom_range(0, 15) * 4);
        v.dwd = $urandom;
        case ($urandom % 4)
          0, 1:    v.dwe = 4'h0;
          2:       v.dwe = 4'hF;
          default: v.dwe = 4'($urandom_range(1, 15));
        endcase
      end
      v.ir  = pi;
      v.dr  = pd;
      v.fl  = ($urandom % 8) == 0;
      v.rst = ($urandom % 150) == 0;
      run_cycle(v);
      if (m_ig) pi = 1'b0;
      if (m_dg) pd = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
